// File: rtl/gate_prober.sv
// Sweeps the four (a,b) vectors into an external 2-input gate, samples its
// response after a settle time and classifies the resulting truth table.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | outputs quiet, waiting for start; results from last sweep held
//   DRIVE | drive vec onto a/b, count settle cycles, capture y on last one
//   DONE  | one-cycle done pulse, classification valid from here on

module gate_prober #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_id,
  output logic       gate_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tt_q, tt_d;
  logic [2:0] id_q, id_d;
  logic       valid_q, valid_d;
  logic [1:0] ab_q, ab_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  function automatic logic [2:0] classify(input logic [3:0] t);
    case (t)
      4'h8:    classify = 3'd0;
      4'hE:    classify = 3'd1;
      4'h3:    classify = 3'd2;
      4'h7:    classify = 3'd3;
      4'h1:    classify = 3'd4;
      4'h6:    classify = 3'd5;
      4'h9:    classify = 3'd6;
      default: classify = 3'd7;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    id_d    = id_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          tt_d    = 4'h0;
          id_d    = 3'd7;
          valid_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          tt_d[vec_q] = y_in;
          cnt_d       = 4'd0;
          if (vec_q == 2'd3) begin
            // Classify the completed table, including the bit captured now.
            state_d = DONE;
            id_d    = classify(tt_d);
            valid_d = (classify(tt_d) != 3'd7);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    ab_d   = (state_d == DRIVE) ? vec_d : 2'b00;
    busy_d = (state_d == DRIVE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 4'h0;
      id_q    <= 3'd7;
      valid_q <= 1'b0;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_out       = ab_q[1];
  assign b_out       = ab_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign gate_id     = id_q;
  assign gate_valid  = valid_q;

endmodule

// File: tb/tb_gate_prober.sv
// Bench for gate_prober: two instances (settle 2 and settle 1) each probing a
// programmable gate model; expectations come from the gate's boolean function.

module tb_gate_prober;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2;
  logic [3:0] f1, f2;

  logic       a1, b1, y1, busy1, done1, valid1;
  logic [3:0] tt1;
  logic [2:0] id1;
  logic       a2, b2, y2, busy2, done2, valid2;
  logic [3:0] tt2;
  logic [2:0] id2;

  // Gate models: the response is the chosen function of the driven vector.
  assign y1 = f1[{a1, b1}];
  assign y2 = f2[{a2, b2}];

  gate_prober #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .y_in(y1), .busy(busy1), .done(done1), .truth_table(tt1),
    .gate_id(id1), .gate_valid(valid1)
  );

  gate_prober #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
    .y_in(y2), .busy(busy2), .done(done2), .truth_table(tt2),
    .gate_id(id2), .gate_valid(valid2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference classification: evaluate each named operator over all (a,b).
  function automatic logic [2:0] exp_id(input logic [3:0] f);
    logic [3:0] t;
    bit a, b;
    for (int g = 0; g < 7; g++) begin
      t = 4'h0;
      for (int v = 0; v < 4; v++) begin
        a = v[1];
        b = v[0];
        case (g)
          0: t[v] = a & b;
          1: t[v] = a | b;
          2: t[v] = ~a;
          3: t[v] = ~(a & b);
          4: t[v] = ~(a | b);
          5: t[v] = a ^ b;
          default: t[v] = ~(a ^ b);
        endcase
      end
      if (t == f) return 3'(g);
    end
    return 3'd7;
  endfunction

  task automatic test_reset();
    n_cmp++;
    if ({a1, b1, busy1, done1, tt1, id1, valid1} !== {4'b0000, 4'h0, 3'd7, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_dut1: ab=%b busy=%b done=%b tt=%h id=%0d valid=%b, want 00 0 0 0 7 0",
               {a1, b1}, busy1, done1, tt1, id1, valid1);
    end
    n_cmp++;
    if ({a2, b2, busy2, done2, tt2, id2, valid2} !== {4'b0000, 4'h0, 3'd7, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_dut2: ab=%b busy=%b done=%b tt=%h id=%0d valid=%b, want 00 0 0 0 7 0",
               {a2, b2}, busy2, done2, tt2, id2, valid2);
    end
  endtask

  // One sweep on dut1 (s=0, settle 2) or dut2 (s=1, settle 1).
  // poke: re-assert start in cycle 3 and in the done cycle.
  // rst_cyc: nonzero drops rst_n in that cycle and checks reset values next cycle.
  task automatic test_sweep(input string name, input bit s, input logic [3:0] f,
                            input bit poke, input int rst_cyc);
    int S, L, busy_cnt, done_cnt, done_at;
    logic [1:0] ab;
    logic bz, dn, vl;
    logic [3:0] tt;
    logic [2:0] id, eid;
    S = s ? 1 : 2;
    L = 1 + 4 * S;
    eid = exp_id(f);
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    if (s) f2 = f; else f1 = f;
    @(negedge clk);
    if (s) start2 = 1'b1; else start1 = 1'b1;
    for (int c = 1; c <= L + 3; c++) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      ab = s ? {a2, b2} : {a1, b1};
      bz = s ? busy2 : busy1;
      dn = s ? done2 : done1;
      tt = s ? tt2 : tt1;
      id = s ? id2 : id1;
      vl = s ? valid2 : valid1;
      if (bz) busy_cnt++;
      if (dn) begin done_cnt++; if (done_at < 0) done_at = c; end
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        n_cmp++;
        if ({ab, bz, dn, tt, id, vl} !== {4'b0000, 4'h0, 3'd7, 1'b0}) begin
          n_bad++;
          $display("FAIL %s_after_reset: ab=%b busy=%b done=%b tt=%h id=%0d valid=%b, want 00 0 0 0 7 0",
                   name, ab, bz, dn, tt, id, vl);
        end
        rst_n = 1'b1;
        return;
      end
      n_cmp++;
      if (c < L) begin
        if (ab !== 2'((c - 1) / S) || bz !== 1'b1 || dn !== 1'b0 || id !== 3'd7 || vl !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_drive_c%0d: ab=%b busy=%b done=%b id=%0d valid=%b, want ab=%b busy=1 done=0 id=7 valid=0",
                   name, c, ab, bz, dn, id, vl, 2'((c - 1) / S));
        end
        if (c == 1) begin
          n_cmp++;
          if (tt !== 4'h0) begin
            n_bad++;
            $display("FAIL %s_tt_cleared: tt=%h, want 0", name, tt);
          end
        end
      end else begin
        if (ab !== 2'b00 || bz !== 1'b0 || dn !== (c == L) || tt !== f || id !== eid || vl !== (eid != 3'd7)) begin
          n_bad++;
          $display("FAIL %s_result_c%0d: ab=%b busy=%b done=%b tt=%h id=%0d valid=%b, want ab=00 busy=0 done=%0d tt=%h id=%0d valid=%0d",
                   name, c, ab, bz, dn, tt, id, vl, (c == L), f, eid, (eid != 3'd7));
        end
      end
      if (rst_cyc != 0 && c == rst_cyc) rst_n = 1'b0;
      if (poke && (c == 3 || c == L)) begin
        if (s) start2 = 1'b1; else start1 = 1'b1;
      end
    end
    start1 = 1'b0; start2 = 1'b0;
    n_cmp++;
    if (busy_cnt != 4 * S || done_cnt != 1 || done_at != L) begin
      n_bad++;
      $display("FAIL %s_timing: busy_cycles=%0d done_pulses=%0d done_cycle=%0d, want %0d 1 %0d",
               name, busy_cnt, done_cnt, done_at, 4 * S, L);
    end
  endtask

  task automatic test_named_gates();
    logic [3:0] tbl [7];
    tbl = '{4'h8, 4'hE, 4'h3, 4'h7, 4'h1, 4'h6, 4'h9};
    for (int i = 0; i < 7; i++) test_sweep($sformatf("gate%0d", i), 1'b0, tbl[i], 1'b0, 0);
  endtask

  task automatic test_constants();
    test_sweep("const0", 1'b0, 4'h0, 1'b0, 0);
    test_sweep("const1", 1'b0, 4'hF, 1'b0, 0);
  endtask

  task automatic test_start_ignored();
    test_sweep("and_poke", 1'b0, 4'h8, 1'b1, 0);
    test_sweep("or_after_poke", 1'b0, 4'hE, 1'b0, 0);
  endtask

  task automatic test_reset_mid_sweep();
    test_sweep("xor_abort", 1'b0, 4'h6, 1'b0, 5);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0 || tt1 !== 4'h0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b tt=%h, want 0 0", busy1, tt1);
    end
    test_sweep("xor_fresh", 1'b0, 4'h6, 1'b0, 0);
  endtask

  task automatic test_settle1();
    test_sweep("xnor_s1", 1'b1, 4'h9, 1'b0, 0);
    test_sweep("nand_s1_poke", 1'b1, 4'h7, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_sweep($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; f1 = 4'h0; f2 = 4'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_named_gates();
    test_constants();
    test_start_ignored();
    test_reset_mid_sweep();
    test_settle1();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
